vend_controller: RTL and testbench

Sequencer for the keypad-driven snack dispenser. Accepts the four debounced keypad levels produced by the button debouncers and decodes a two-digit slot selection followed by a confirm key. On a valid, paid selection it drives exactly one motor line for a fixed run time, then reports completion. It sits between the debouncer bank and the motor pins, and provides state, slot and error outputs for the LED and HEX displays.

---
 rtl/vend_pkg.sv | 38 +++
 rtl/key_edge_detect.sv | 33 +++
 rtl/vend_controller.sv | 153 +++++++++++++++
 tb/tb_vend_controller.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// Shared types and constants for the snack-dispenser sequencer:
// FSM state encoding, default timing and the phase LED map.
package vend_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_GOT1 = 3'd1,
        ST_GOT2 = 3'd2,
        ST_VEND = 3'd3,
        ST_ERR  = 3'd4
    } state_e;

    localparam int DEF_NUM_MOTORS    = 8;
    localparam int DEF_MOTOR_CYCLES  = 50_000_000;
    localparam int DEF_ENTRY_TIMEOUT = 250_000_000;
    localparam int DEF_ERR_CYCLES    = 25_000_000;
    localparam int DEF_CONFIRM_KEY   = 3;

    localparam logic [3:0] LEDS_IDLE = 4'b0001;
    localparam logic [3:0] LEDS_GOT1 = 4'b0010;
    localparam logic [3:0] LEDS_GOT2 = 4'b0100;
    localparam logic [3:0] LEDS_VEND = 4'b1000;
    localparam logic [3:0] LEDS_NONE = 4'b0000;

    // ERR has no phase LED of its own; the err output lights instead.
    function automatic logic [3:0] state_leds_of(input state_e s);
        logic [3:0] leds;
        case (s)
            ST_IDLE: leds = LEDS_IDLE;
            ST_GOT1: leds = LEDS_GOT1;
            ST_GOT2: leds = LEDS_GOT2;
            ST_VEND: leds = LEDS_VEND;
            default: leds = LEDS_NONE;
        endcase
        return leds;
    endfunction

endpackage

// File: rtl/key_edge_detect.sv
// Rising-edge detection on the four debounced keys; a press is reported
// only when exactly one key rises in a cycle.
module key_edge_detect (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] i_btn,
    output logic       o_press_valid,
    output logic [1:0] o_press_key
);

    logic [3:0] r_btn_q;
    logic [3:0] w_rise;

    // Reset to all-ones so a key held through reset never looks like a new press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_btn_q <= 4'b1111;
        end else begin
            r_btn_q <= i_btn;
        end
    end

    assign w_rise        = i_btn & ~r_btn_q;
    assign o_press_valid = $onehot(w_rise);

    always_comb begin
        o_press_key = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (w_rise[i]) o_press_key = 2'(i);
        end
    end

endmodule

// File: rtl/vend_controller.sv
// Keypad sequencer: two digits plus confirm select a slot, then one motor
// runs for a fixed time. One counter serves entry timeout, vend and error.
module vend_controller
    import vend_pkg::*;
#(
    parameter int NUM_MOTORS    = DEF_NUM_MOTORS,
    parameter int MOTOR_CYCLES  = DEF_MOTOR_CYCLES,
    parameter int ENTRY_TIMEOUT = DEF_ENTRY_TIMEOUT,
    parameter int ERR_CYCLES    = DEF_ERR_CYCLES,
    parameter int CONFIRM_KEY   = DEF_CONFIRM_KEY
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [3:0]            btn_db,
    input  logic                  credit,
    output logic [NUM_MOTORS-1:0] motors,
    output logic [3:0]            slot,
    output logic [3:0]            state_leds,
    output logic                  busy,
    output logic                  err,
    output logic                  vend_done,
    output logic [2:0]            dbg_state
);

    localparam int MAX_A   = (MOTOR_CYCLES > ENTRY_TIMEOUT) ? MOTOR_CYCLES : ENTRY_TIMEOUT;
    localparam int MAX_CYC = (MAX_A > ERR_CYCLES) ? MAX_A : ERR_CYCLES;
    localparam int CW      = $clog2(MAX_CYC + 1);

    localparam logic [CW-1:0] MC_LAST  = CW'(MOTOR_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST  = CW'(ENTRY_TIMEOUT - 1);
    localparam logic [CW-1:0] EC_LAST  = CW'(ERR_CYCLES - 1);
    localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};
    localparam logic [1:0]    CONF_KEY = 2'(CONFIRM_KEY);

    state_e                r_state;
    logic [3:0]            r_slot;
    logic [CW-1:0]         r_cnt;
    logic [NUM_MOTORS-1:0] r_motors;
    logic [3:0]            r_leds;
    logic                  r_busy;
    logic                  r_err;
    logic                  r_vend_done;

    logic                  w_press_valid;
    logic [1:0]            w_press_key;
    logic                  w_slot_ok;
    logic [NUM_MOTORS-1:0] w_onehot;

    key_edge_detect u_key_edge_detect (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_btn         (btn_db),
        .o_press_valid (w_press_valid),
        .o_press_key   (w_press_key)
    );

    assign w_slot_ok = ({1'b0, r_slot} < 5'(NUM_MOTORS));
    assign w_onehot  = NUM_MOTORS'(1) << r_slot;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_slot      <= 4'd0;
            r_cnt       <= '0;
            r_motors    <= '0;
            r_leds      <= state_leds_of(ST_IDLE);
            r_busy      <= 1'b0;
            r_err       <= 1'b0;
            r_vend_done <= 1'b0;
        end else begin
            r_vend_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_cnt <= '0;
                    if (w_press_valid) begin
                        r_slot[3:2] <= w_press_key;
                        r_state     <= ST_GOT1;
                        r_leds      <= state_leds_of(ST_GOT1);
                    end
                end
                ST_GOT1, ST_GOT2: begin
                    if (w_press_valid) begin
                        r_cnt <= '0;
                        if (r_state == ST_GOT1) begin
                            r_slot[1:0] <= w_press_key;
                            r_state     <= ST_GOT2;
                            r_leds      <= state_leds_of(ST_GOT2);
                        end else if (w_press_key == CONF_KEY && w_slot_ok && credit) begin
                            r_motors <= w_onehot;
                            r_busy   <= 1'b1;
                            r_state  <= ST_VEND;
                            r_leds   <= state_leds_of(ST_VEND);
                        end else begin
                            r_err   <= 1'b1;
                            r_state <= ST_ERR;
                            r_leds  <= state_leds_of(ST_ERR);
                        end
                    end else if (r_cnt == TO_LAST) begin
                        // Abandoned entry: quietly back to IDLE without an error.
                        r_cnt   <= '0;
                        r_slot  <= 4'd0;
                        r_state <= ST_IDLE;
                        r_leds  <= state_leds_of(ST_IDLE);
                    end else if (r_cnt != CNT_MAX) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_VEND: begin
                    if (r_cnt == MC_LAST) begin
                        r_cnt       <= '0;
                        r_motors    <= '0;
                        r_busy      <= 1'b0;
                        r_vend_done <= 1'b1;
                        r_slot      <= 4'd0;
                        r_state     <= ST_IDLE;
                        r_leds      <= state_leds_of(ST_IDLE);
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_ERR: begin
                    if (r_cnt == EC_LAST) begin
                        r_cnt   <= '0;
                        r_err   <= 1'b0;
                        r_slot  <= 4'd0;
                        r_state <= ST_IDLE;
                        r_leds  <= state_leds_of(ST_IDLE);
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_cnt    <= '0;
                    r_slot   <= 4'd0;
                    r_motors <= '0;
                    r_busy   <= 1'b0;
                    r_err    <= 1'b0;
                    r_state  <= ST_IDLE;
                    r_leds   <= state_leds_of(ST_IDLE);
                end
            endcase
        end
    end

    assign motors     = r_motors;
    assign slot       = r_slot;
    assign state_leds = r_leds;
    assign busy       = r_busy;
    assign err        = r_err;
    assign vend_done  = r_vend_done;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_vend_controller.sv
// Bench for vend_controller: each vend or error is recorded by a monitor as
// {kind, motors seen, cycle length} and matched against an expected queue.
module tb_vend_controller;

  localparam int NM = 8;

  logic          clk;
  logic          rst_n;
  logic [3:0]    btn_db;
  logic          credit;
  logic [NM-1:0] motors;
  logic [3:0]    slot;
  logic [3:0]    state_leds;
  logic          busy;
  logic          err;
  logic          vend_done;
  logic [2:0]    dbg_state;

  logic [17:0] exp_q[$];
  int n_vec;
  int n_err;
  int n_done;
  int run_len;
  int err_len;
  logic [7:0] run_mot;
  logic [7:0] err_mot;

  vend_controller #(
    .NUM_MOTORS    (NM),
    .MOTOR_CYCLES  (10),
    .ENTRY_TIMEOUT (20),
    .ERR_CYCLES    (5),
    .CONFIRM_KEY   (3)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_db     (btn_db),
    .credit     (credit),
    .motors     (motors),
    .slot       (slot),
    .state_leds (state_leds),
    .busy       (busy),
    .err        (err),
    .vend_done  (vend_done),
    .dbg_state  (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic sb_pop(input logic [17:0] got);
    if (exp_q.size() == 0) check_eq("sb_unexpected", 32'(got), 32'd0);
    else check_eq("sb_result", 32'(got), 32'(exp_q.pop_front()));
  endtask

  // monitor: builds one record per completed vend or error episode
  always @(negedge clk) begin
    if (!rst_n) begin
      run_len = 0; err_len = 0; run_mot = 8'h00; err_mot = 8'h00;
    end else begin
      if (motors != 0) begin run_len++; run_mot = run_mot | motors; end
      if (err) begin err_len++; err_mot = err_mot | motors; end
      if (vend_done) begin
        n_done++;
        sb_pop({2'd1, run_mot | motors, 8'(run_len)});
        run_len = 0; run_mot = 8'h00;
      end
      if (!err && err_len != 0) begin
        sb_pop({2'd2, err_mot, 8'(err_len)});
        err_len = 0; err_mot = 8'h00;
      end
    end
  end

  // driver tasks
  task automatic press(input int k);
    @(negedge clk);
    btn_db = 4'b0001 << k;
    repeat (2) @(negedge clk);
    btn_db = 4'b0000;
    @(negedge clk);
  endtask

  task automatic wait_idle(input int budget);
    int i;
    i = 0;
    while (dbg_state != 3'd0 && i < budget) begin
      @(negedge clk);
      i++;
    end
    check_eq("idle_reached", 32'(dbg_state == 3'd0), 32'd1);
  endtask

  initial begin
    n_vec = 0; n_err = 0; n_done = 0;
    run_len = 0; err_len = 0; run_mot = 8'h00; err_mot = 8'h00;
    rst_n = 1'b0; btn_db = 4'b0000; credit = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_motors", 32'(motors), 32'd0);
    check_eq("rst_slot", 32'(slot), 32'd0);
    check_eq("rst_leds", 32'(state_leds), 32'b0001);
    check_eq("rst_busy_err_done", {29'd0, busy, err, vend_done}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // keys 1,0,3 with credit -> slot 4, motor 4 for 10 cycles
    credit = 1'b1;
    press(1);
    press(0);
    check_eq("slot_after_two", 32'(slot), 32'd4);
    check_eq("leds_got2", 32'(state_leds), 32'b0100);
    exp_q.push_back({2'd1, 8'h10, 8'd10});
    press(3);
    check_eq("leds_vend", 32'(state_leds), 32'b1000);
    check_eq("busy_vend", 32'(busy), 32'd1);
    check_eq("motors_vend", 32'(motors), 32'h10);
    press(0);
    wait_idle(40);
    check_eq("slot_after_vend", 32'(slot), 32'd0);
    check_eq("leds_after_vend", 32'(state_leds), 32'b0001);

    // keys 2,2,3 -> slot 10 out of range -> 5-cycle error
    press(2);
    press(2);
    check_eq("slot_ten", 32'(slot), 32'd10);
    exp_q.push_back({2'd2, 8'h00, 8'd5});
    press(3);
    check_eq("err_high", 32'(err), 32'd1);
    wait_idle(40);
    check_eq("slot_after_err", 32'(slot), 32'd0);

    // keys 0,1,3 without credit -> error
    credit = 1'b0;
    press(0);
    press(1);
    exp_q.push_back({2'd2, 8'h00, 8'd5});
    press(3);
    wait_idle(40);

    // non-confirm key in GOT2 -> error
    credit = 1'b1;
    press(0);
    press(0);
    exp_q.push_back({2'd2, 8'h00, 8'd5});
    press(1);
    wait_idle(40);

    // entry timeout: GOT1 at cycle 19 after the press, IDLE at cycle 20
    press(0);
    check_eq("leds_got1", 32'(state_leds), 32'b0010);
    repeat (17) @(negedge clk);
    check_eq("timeout_edge_minus1", 32'(state_leds), 32'b0010);
    @(negedge clk);
    check_eq("timeout_leds", 32'(state_leds), 32'b0001);
    check_eq("timeout_slot_err", {27'd0, slot, err}, 32'd0);
    press(0);
    check_eq("restart_got1", 32'(state_leds), 32'b0010);
    repeat (25) @(negedge clk);
    check_eq("restart_timeout", 32'(state_leds), 32'b0001);

    // two keys rising together are ignored
    @(negedge clk);
    btn_db = 4'b0101;
    repeat (2) @(negedge clk);
    check_eq("double_ignored", 32'(state_leds), 32'b0001);
    btn_db = 4'b0000;
    @(negedge clk);

    // key held through reset release is not a press
    btn_db = 4'b0010;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("held_through_reset", 32'(state_leds), 32'b0001);
    btn_db = 4'b0000;
    @(negedge clk);

    // reset four cycles into a vend: motors drop at once, no vend_done
    press(1);
    press(1);
    press(3);
    check_eq("motors_slot5", 32'(motors), 32'h20);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("midvend_motors", 32'(motors), 32'd0);
    check_eq("midvend_leds", 32'(state_leds), 32'b0001);
    check_eq("midvend_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    check_eq("post_reset_motors", 32'(motors), 32'd0);

    // final report
    check_eq("vend_done_count", 32'(n_done), 32'd1);
    check_eq("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
